// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip memory.
// Read data returns one cycle after accept and is steered by a pending-read tag.
module onchip_mem_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,

    input  logic              cnt_clear,
    output logic [CNT_W-1:0]  conflict_count
);

    // last_grant | meaning
    // MST_M0     | m0 won most recently; m1 wins the next conflict
    // MST_M1     | m1 won most recently (reset); m0 wins the next conflict
    typedef enum logic {
        MST_M0 = 1'b0,
        MST_M1 = 1'b1
    } master_t;

    master_t            last_grant;
    master_t            last_grant_next;
    logic               req0;
    logic               req1;
    logic               gnt0;
    logic               gnt1;
    logic [1:0]         pend;
    logic [CNT_W-1:0]   count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= MST_M1;
        end else begin
            last_grant <= last_grant_next;
        end
    end

    always_comb begin
        req0            = m0_read | m0_write;
        req1            = m1_read | m1_write;
        gnt0            = 1'b0;
        gnt1            = 1'b0;
        last_grant_next = last_grant;
        if (req0 && req1) begin
            if (last_grant == MST_M1) begin
                gnt0 = 1'b1;
            end else begin
                gnt1 = 1'b1;
            end
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
        if (gnt0) begin
            last_grant_next = MST_M0;
        end else if (gnt1) begin
            last_grant_next = MST_M1;
        end
    end

    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_write      = 1'b0;
        mem_writedata  = '0;
        if (gnt0) begin
            mem_address    = m0_address;
            mem_byteenable = m0_byteenable;
            mem_write      = m0_write;
            mem_writedata  = m0_writedata;
        end else if (gnt1) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_write      = m1_write;
            mem_writedata  = m1_writedata;
        end
    end

    assign mem_chipselect = gnt0 | gnt1;
    assign mem_clken      = 1'b1;
    assign m0_waitrequest = ~gnt0;
    assign m1_waitrequest = ~gnt1;

    // A read with write asserted alongside is a write, so it never tags a return.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend <= 2'b00;
        end else begin
            pend <= {gnt1 & m1_read & ~m1_write, gnt0 & m0_read & ~m0_write};
        end
    end

    assign m0_readdatavalid = pend[0];
    assign m1_readdatavalid = pend[1];
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (cnt_clear) begin
            count <= '0;
        end else if (req0 && req1 && (count != {CNT_W{1'b1}})) begin
            count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign conflict_count = count;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a one-cycle-latency byte-lane memory model.
module tb_onchip_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [14:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [14:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = 32'h0;
    logic        cnt_clear;
    logic [15:0] conflict_count;

    int checks = 0;
    int failures = 0;

    logic [31:0] ram [0:32767];

    always #5 clk = ~clk;

    onchip_mem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable),
        .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable),
        .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata),
        .cnt_clear(cnt_clear), .conflict_count(conflict_count)
    );

    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        ram[15'h100] = 32'hA0A0_0100;
        ram[15'h200] = 32'hB1B1_0200;
        reset_n = 1'b0;
        cnt_clear = 1'b0;
        m0_address = '0; m0_byteenable = '0; m0_read = 0; m0_write = 0; m0_writedata = '0;
        m1_address = '0; m1_byteenable = '0; m1_read = 0; m1_write = 0; m1_writedata = '0;

        // In reset, idle
        #2;
        chk("rst_m0_wait", m0_waitrequest, 1);
        chk("rst_m1_wait", m1_waitrequest, 1);
        chk("rst_m0_rdv", m0_readdatavalid, 0);
        chk("rst_m1_rdv", m1_readdatavalid, 0);
        chk("rst_count", conflict_count, 0);
        chk("rst_cs", mem_chipselect, 0);
        chk("clken", mem_clken, 1);
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk); #1;
        chk("idle_m0_wait", m0_waitrequest, 1);
        chk("idle_m1_wait", m1_waitrequest, 1);
        chk("idle_cs", mem_chipselect, 0);

        // Both masters read for 6 cycles: m0 first, then alternate
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            m0_read = 1; m0_address = 15'h100;
            m1_read = 1; m1_address = 15'h200;
            #1;
            chk("rr_m0_wait", m0_waitrequest, (i % 2 == 0) ? 32'd0 : 32'd1);
            chk("rr_m1_wait", m1_waitrequest, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_addr", mem_address, (i % 2 == 0) ? 32'h100 : 32'h200);
            if (i > 0) begin
                chk("rr_m0_rdv", m0_readdatavalid, (i % 2 == 1) ? 32'd1 : 32'd0);
                chk("rr_m1_rdv", m1_readdatavalid, (i % 2 == 0) ? 32'd1 : 32'd0);
                if (i % 2 == 1) chk("rr_m0_data", m0_readdata, 32'hA0A0_0100);
                else            chk("rr_m1_data", m1_readdata, 32'hB1B1_0200);
            end
        end
        @(negedge clk); m0_read = 0; m1_read = 0; #1;
        chk("rr_last_m0_rdv", m0_readdatavalid, 0);
        chk("rr_last_m1_rdv", m1_readdatavalid, 1);
        chk("rr_last_data", m1_readdata, 32'hB1B1_0200);
        chk("rr_count", conflict_count, 6);

        // m0 write then read back
        @(negedge clk);
        m0_write = 1; m0_address = 15'h0010; m0_byteenable = 4'hF; m0_writedata = 32'hDEADBEEF;
        #1;
        chk("wr_m0_wait", m0_waitrequest, 0);
        chk("wr_cs", mem_chipselect, 1);
        chk("wr_we", mem_write, 1);
        chk("wr_addr", mem_address, 32'h10);
        chk("wr_data", mem_writedata, 32'hDEADBEEF);
        chk("wr_be", mem_byteenable, 4'hF);
        @(negedge clk); m0_write = 0; m0_read = 1; #1;
        chk("rd_m0_wait", m0_waitrequest, 0);
        chk("rd_we", mem_write, 0);
        chk("wr_no_rdv", m0_readdatavalid, 0);
        @(negedge clk); m0_read = 0; #1;
        chk("rd_m0_rdv", m0_readdatavalid, 1);
        chk("rd_m0_data", m0_readdata, 32'hDEADBEEF);
        chk("rd_m1_rdv", m1_readdatavalid, 0);

        // Read and write together count as a write with no return
        @(negedge clk);
        m1_read = 1; m1_write = 1; m1_address = 15'h0020; m1_byteenable = 4'hF; m1_writedata = 32'h0BADF00D;
        #1;
        chk("rw_we", mem_write, 1);
        @(negedge clk); m1_read = 0; m1_write = 0; #1;
        chk("rw_no_rdv", m1_readdatavalid, 0);

        // Byte-lane write by m1 over existing word
        @(negedge clk);
        m0_write = 1; m0_address = 15'h7FFF; m0_byteenable = 4'hF; m0_writedata = 32'h11223344;
        @(negedge clk);
        m0_write = 0;
        m1_write = 1; m1_address = 15'h7FFF; m1_byteenable = 4'h1; m1_writedata = 32'h000000AA;
        #1;
        chk("bl_m1_wait", m1_waitrequest, 0);
        chk("bl_be", mem_byteenable, 4'h1);
        @(negedge clk); m1_write = 0; m0_read = 1; m0_address = 15'h7FFF;
        @(negedge clk); m0_read = 0; #1;
        chk("bl_rdv", m0_readdatavalid, 1);
        chk("bl_data", m0_readdata, 32'h112233AA);

        // Saturation and clear priority
        @(negedge clk); cnt_clear = 1;
        @(negedge clk); cnt_clear = 0; #1;
        chk("clr_count", conflict_count, 0);
        m0_read = 1; m0_address = 15'h100; m1_read = 1; m1_address = 15'h200;
        repeat (65534) @(negedge clk);
        #1;
        chk("sat_fffe", conflict_count, 32'hFFFE);
        repeat (3) @(negedge clk);
        #1;
        chk("sat_ffff", conflict_count, 32'hFFFF);
        cnt_clear = 1;
        @(negedge clk); #1;
        chk("clr_prio", conflict_count, 0);
        cnt_clear = 0; m0_read = 0; m1_read = 0;

        // Reset while an m1 read is pending
        @(negedge clk); m1_read = 1; m1_address = 15'h200; #1;
        chk("mr_m1_wait", m1_waitrequest, 0);
        #2; reset_n = 1'b0; #1;
        chk("mr_inrst_wait", m1_waitrequest, 0);
        chk("mr_inrst_rdv", m1_readdatavalid, 0);
        @(negedge clk); m1_read = 0; #1;
        chk("mr_rdv_dropped", m1_readdatavalid, 0);
        reset_n = 1'b1;
        @(negedge clk); m0_read = 1; m0_address = 15'h100; m1_read = 1; #1;
        chk("mr_m0_wins", m0_waitrequest, 0);
        chk("mr_m1_loses", m1_waitrequest, 1);
        @(negedge clk); m0_read = 0; m1_read = 0; #1;
        chk("mr_m0_rdv", m0_readdatavalid, 1);
        chk("mr_m1_rdv", m1_readdatavalid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
